// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS fetch stage: PC, imem req/ready handshake, IF/ID register, one-entry hold buffer
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_stage #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [5:0]          BUBBLE_OP = 6'b111111
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                jump,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc_plus4,
  output logic [5:0]          op
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [15:0]         perf_flushes
`endif
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t              state, state_next;
  logic [31:0]         hold_instr;
  logic [PC_WIDTH-1:0] hold_pc_plus4;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                pc_adv;
  logic                load_from_mem;
  logic                load_from_hold;
  logic                load_hold;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign op        = ifid_valid ? ifid_instr[31:26] : BUBBLE_OP;

  always_comb begin
    state_next     = state;
    imem_req       = 1'b0;
    pc_adv         = 1'b0;
    load_from_mem  = 1'b0;
    load_from_hold = 1'b0;
    load_hold      = 1'b0;
    redirect       = branch_taken | (jump & ifid_valid);
    // Branch wins over jump; low bits are forced so the PC stays word aligned.
    if (branch_taken) begin
      target = {branch_target[PC_WIDTH-1:2], 2'b00};
    end else begin
      target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00};
    end
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (!redirect && imem_ready) begin
          pc_adv = 1'b1;
          if (stall) begin
            load_hold  = 1'b1;
            state_next = HOLD;
          end else begin
            load_from_mem = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!redirect && !stall) begin
          load_from_hold = 1'b1;
          state_next     = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
    // A redirect empties the hold buffer simply by leaving HOLD.
    if (redirect) begin
      state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= 32'd0;
      ifid_pc_plus4 <= '0;
      hold_instr    <= 32'd0;
      hold_pc_plus4 <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc         <= target;
        ifid_valid <= 1'b0;
      end else if (pc_adv) begin
        pc <= pc_plus4;
      end
      if (load_from_mem) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= imem_rdata;
        ifid_pc_plus4 <= pc_plus4;
      end
      if (load_from_hold) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= hold_instr;
        ifid_pc_plus4 <= hold_pc_plus4;
      end
      if (load_hold) begin
        hold_instr    <= imem_rdata;
        hold_pc_plus4 <= pc_plus4;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_flushes <= 16'd0;
    end else begin
      if (load_from_mem || load_from_hold) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_flushes <= perf_flushes + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed vector table plus randomized run against a queue-based fetch model
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, imem_ready, stall, jump, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc_plus4;
  logic [5:0]  op;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flushes;
`endif

  instruction_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .op(op)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        jmp;
    logic        br;
    logic [31:0] btgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [5:0]  e_op;
    logic [31:0] e_pc4;
    logic        e_req;
  } vec_t;

  vec_t vec[20];

  // Behavioural model: IF/ID contents plus a queue acting as the hold buffer.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] hq_instr[$];
  logic [31:0] hq_pc4[$];
  logic [31:0] m_fetched;
  logic [15:0] m_flushes;

  task automatic drive(input logic r, input logic rdy, input logic [31:0] rd, input logic s,
                       input logic j, input logic b, input logic [31:0] bt);
    reset = r; imem_ready = rdy; imem_rdata = rd; stall = s;
    jump = j; branch_taken = b; branch_target = bt;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      hq_instr.delete(); hq_pc4.delete();
      m_fetched = 32'h0; m_flushes = 16'h0;
    end else if (branch_taken || (jump && m_valid)) begin
      if (branch_taken) tgt = branch_target;
      else tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      m_pc = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      hq_instr.delete(); hq_pc4.delete();
      m_flushes = m_flushes + 16'd1;
    end else if (hq_instr.size() != 0) begin
      if (!stall) begin
        m_instr = hq_instr.pop_front();
        m_pc4   = hq_pc4.pop_front();
        m_valid = 1'b1;
        m_fetched = m_fetched + 1;
      end
    end else if (imem_ready) begin
      if (stall) begin
        hq_instr.push_back(imem_rdata);
        hq_pc4.push_back(m_pc + 4);
      end else begin
        m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1'b1;
        m_fetched = m_fetched + 1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  task automatic check_model();
    logic [5:0] m_op;
    m_op = m_valid ? m_instr[31:26] : 6'h3F;
    chk("rnd_pc", pc, m_pc);
    chk("rnd_req", {31'd0, imem_req}, {31'd0, hq_instr.size() == 0});
    chk("rnd_addr", imem_addr, m_pc);
    chk("rnd_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("rnd_op", {26'd0, op}, {26'd0, m_op});
    if (m_valid) begin
      chk("rnd_instr", ifid_instr, m_instr);
      chk("rnd_pc4", ifid_pc_plus4, m_pc4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetched", perf_fetched, m_fetched);
    chk("rnd_perf_flushes", {16'd0, perf_flushes}, {16'd0, m_flushes});
`endif
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'h3F, 32'h0,   1'b1};
    vec[1]  = '{1'b0, 1'b1, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 6'h23, 32'h4,   1'b1};
    vec[2]  = '{1'b0, 1'b1, 32'hAC01_0008, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         1'b1, 6'h2B, 32'h8,   1'b1};
    vec[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h100,       32'h100,       1'b0, 6'h3F, 32'h0,   1'b1};
    vec[4]  = '{1'b0, 1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 32'h0,         32'h104,       1'b1, 6'h02, 32'h104, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 32'h8C01_0004, 1'b0, 1'b1, 1'b0, 32'h0,         32'h40,        1'b0, 6'h3F, 32'h0,   1'b1};
    vec[6]  = '{1'b0, 1'b1, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        1'b1, 6'h23, 32'h44,  1'b1};
    vec[7]  = '{1'b0, 1'b1, 32'hAC01_000C, 1'b1, 1'b0, 1'b0, 32'h0,         32'h48,        1'b1, 6'h23, 32'h44,  1'b0};
    vec[8]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,         32'h48,        1'b1, 6'h23, 32'h44,  1'b0};
    vec[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h48,        1'b1, 6'h23, 32'h44,  1'b0};
    vec[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h48,        1'b1, 6'h2B, 32'h48,  1'b1};
    vec[11] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4C,        1'b1, 6'h00, 32'h4C,  1'b1};
    vec[12] = '{1'b0, 1'b1, 32'hAC01_0010, 1'b1, 1'b0, 1'b0, 32'h0,         32'h50,        1'b1, 6'h00, 32'h4C,  1'b0};
    vec[13] = '{1'b0, 1'b1, 32'h8C01_0004, 1'b1, 1'b1, 1'b1, 32'h200,       32'h200,       1'b0, 6'h3F, 32'h0,   1'b1};
    vec[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h200,       1'b0, 6'h3F, 32'h0,   1'b1};
    vec[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 6'h3F, 32'h0,   1'b1};
    vec[16] = '{1'b0, 1'b1, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 6'h23, 32'h0,   1'b1};
    vec[17] = '{1'b0, 1'b1, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 6'h02, 32'h4,   1'b1};
    vec[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0FFF_FFFC, 1'b0, 6'h3F, 32'h0,   1'b1};
    vec[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0FFF_FFFC, 1'b0, 6'h3F, 32'h0,   1'b1};

    for (int i = 0; i < 20; i++) begin
      drive(vec[i].rst, vec[i].rdy, vec[i].rdata, vec[i].stl, vec[i].jmp, vec[i].br, vec[i].btgt);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_pc", i), pc, vec[i].e_pc);
      chk($sformatf("vec%0d_addr", i), imem_addr, vec[i].e_pc);
      chk($sformatf("vec%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vec[i].e_valid});
      chk($sformatf("vec%0d_op", i), {26'd0, op}, {26'd0, vec[i].e_op});
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vec[i].e_req});
      if (vec[i].e_valid) chk($sformatf("vec%0d_pc4", i), ifid_pc_plus4, vec[i].e_pc4);
    end

    // Randomized run: reset with a stray ready, then random traffic.
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), $urandom(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) == 0), $urandom());
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front end of the MIPS datapath: holds the PC, fetches from instruction memory over a req/ready handshake, and loads the IF/ID pipeline register. Drives the 6-bit opcode consumed directly by the main control decoder, and takes that decoder's Jump decision back in to redirect fetch. Supports hazard stalls, flushes and a one-entry hold buffer.

Parameters:
PC_WIDTH, 32, PC/address width; must be 32 (jump target assumes MIPS J-format).
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
BUBBLE_OP, 6'b111111, opcode driven when IF/ID is invalid; decodes to all control outputs 0.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high.
imem_req  output  1  fetch request, held high until imem_ready.
imem_addr  output  32  fetch address (= pc while imem_req=1).
imem_ready  input  1  imem_rdata valid this cycle; completes the request.
imem_rdata  input  32  instruction word.
stall  input  1  hazard unit: hold IF/ID contents this cycle.
jump  input  1  main control Jump for instruction in IF/ID.
branch_taken  input  1  Branch & Zero from the later stage.
branch_target  input  32  resolved branch address.
pc  output  32  current fetch PC.
ifid_valid  output  1  IF/ID holds a real instruction.
ifid_instr  output  32  IF/ID instruction.
ifid_pc_plus4  output  32  PC+4 of the IF/ID instruction.
op  output  6  ifid_valid ? ifid_instr[31:26] : BUBBLE_OP.

Behaviour:
- One clock; reset is synchronous and active-high. Reset: pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, hold buffer empty, state=FETCH. Response to an in-flight request is abandoned; imem_ready in the reset cycle is ignored.
- States: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc. Without imem_ready: stay, pc unchanged, IF/ID unchanged unless a redirect occurs.
- Redirect = branch_taken | (jump & ifid_valid). Target: branch_taken has priority and uses branch_target. Otherwise the jump target is {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}. Target bits [1:0] are forced to 0.
- Redirect, in any state, overrides stall. Next edge: pc=target, ifid_valid=0, hold buffer cleared, state=FETCH. A fetch response arriving the same cycle is discarded. An outstanding request is re-issued at the new pc, and memory must accept the address change.
- FETCH with imem_ready, no redirect, stall=0: ifid_instr=imem_rdata, ifid_pc_plus4=pc+4, ifid_valid=1, pc=pc+4. The latency from ready to op is 1 cycle.
- FETCH with imem_ready, no redirect, stall=1: IF/ID unchanged. Word and pc+4 go to the hold buffer, pc=pc+4, state=HOLD.
- HOLD: imem_req=0. While stall=1, hold. When stall=0 and no redirect, move the buffer into IF/ID (valid=1) and return to FETCH.
- FETCH with stall=1 and no response: IF/ID held; the request continues.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. ifid_pc_plus4 wraps identically.
- Back-to-back fetches are allowed: with imem_ready held high and no stall, one instruction per cycle.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs perf_fetched[31:0] and perf_flushes[15:0].
- perf_fetched counts instructions written into IF/ID, including from the hold buffer.
- perf_flushes counts redirect cycles.
- Both reset to 0 and wrap silently.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then imem_ready=1 continuously with words 0x8C010004, 0xAC010008 -> imem_addr 0,4,8. op=6'h23 one cycle after the first ready, then 6'h2B, with ifid_pc_plus4 4, 8.
2. Reset only -> ifid_valid=0, op=6'b111111, pc=RESET_PC, imem_req=1.
3. IF/ID holds 0x08000010 (J) at ifid_pc_plus4=0x0000_0104, jump=1 -> next cycle pc=0x0000_0040, ifid_valid=0. Concurrent fetch response discarded.
4. Response arrives with stall=1 for 3 cycles -> IF/ID unchanged, imem_req=0 in HOLD. First cycle after stall drops: buffered word in IF/ID, FETCH resumes at pc+4.
5. branch_taken=1 (target 0x200) and jump=1 together with stall=1 -> pc=0x200, IF/ID flushed, hold buffer cleared. With the macro, perf_flushes increments by 1.
6. pc=0xFFFF_FFFC, fetch completes -> pc=0, ifid_pc_plus4=0.
